// File: rtl/fir_coeff_ctrl.sv
// Coefficient loader for fir_transpose: streams NTAPS taps into the filter while it
// is halted, optionally reads them back for a checksum, flushes, then releases to RUN.
module fir_coeff_ctrl #(
    parameter int NTAPS = 16,
    parameter int CW    = 12,
    parameter int AW    = 8,
    parameter int SUMW  = 16
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          cfg_start,
    input  logic          verify_en,
    input  logic          coef_valid,
    output logic          coef_ready,
    input  logic [CW-1:0] coef_data,
    output logic          fir_hlt,
    output logic          fir_load,
    output logic [AW-1:0] fir_write_address,
    output logic [CW-1:0] fir_write_value,
    output logic [AW-1:0] fir_read_address,
    input  logic [CW-1:0] fir_read_value,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {IDLE, WRITE, WDRAIN, VERIFY, FLUSH, RUN} state_t;

    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            ver_q, ver_d;
    logic [SUMW-1:0] wsum_q, wsum_d;
    logic [SUMW-1:0] rsum_q, rsum_d;
    logic            err_q, err_d;
    logic            load_q, load_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [CW-1:0]   wval_q, wval_d;
    logic            hlt_q, hlt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            hs;

    assign coef_ready        = (state_q == WRITE);
    assign hs                = coef_valid && coef_ready;
    assign fir_hlt           = hlt_q;
    assign fir_load          = load_q;
    assign fir_write_address = waddr_q;
    assign fir_write_value   = wval_q;
    assign fir_read_address  = idx_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ver_d   = ver_q;
        wsum_d  = wsum_q;
        rsum_d  = rsum_q;
        err_d   = err_q;
        load_d  = 1'b0;
        waddr_d = waddr_q;
        wval_d  = wval_q;

        case (state_q)
            IDLE, RUN: begin
                if (cfg_start) begin
                    state_d = WRITE;
                    idx_d   = '0;
                    wsum_d  = '0;
                    rsum_d  = '0;
                    err_d   = 1'b0;
                    ver_d   = verify_en;
                end
            end
            WRITE: begin
                if (hs) begin
                    load_d  = 1'b1;
                    waddr_d = idx_q;
                    wval_d  = coef_data;
                    wsum_d  = wsum_q + SUMW'(coef_data);
                    if (idx_q == LAST) state_d = WDRAIN;
                    else               idx_d   = idx_q + 1'b1;
                end
            end
            WDRAIN: begin
                idx_d   = '0;
                state_d = ver_q ? VERIFY : FLUSH;
            end
            VERIFY: begin
                // Read data is combinational, so the sample for idx lands this cycle.
                rsum_d = rsum_q + SUMW'(fir_read_value);
                if (idx_q == LAST) begin
                    err_d   = (rsum_d != wsum_q);
                    idx_d   = '0;
                    state_d = FLUSH;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            FLUSH: begin
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Halt drops (and done pulses) only once RUN has been held for a full cycle.
        hlt_d  = !((state_q == RUN) && (state_d == RUN));
        done_d = (state_q == RUN) && (state_d == RUN) && hlt_q;
        busy_d = (state_d != IDLE) && hlt_d;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ver_q   <= 1'b0;
            wsum_q  <= '0;
            rsum_q  <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            waddr_q <= '0;
            wval_q  <= '0;
            hlt_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ver_q   <= ver_d;
            wsum_q  <= wsum_d;
            rsum_q  <= rsum_d;
            err_q   <= err_d;
            load_q  <= load_d;
            waddr_q <= waddr_d;
            wval_q  <= wval_d;
            hlt_q   <= hlt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed + randomized bench for fir_coeff_ctrl with a coefficient memory model
// and a cycle-count / checksum reference derived from the sequencer's rules.
module tb_fir_coeff_ctrl;
    localparam int N  = 16;
    localparam int CW = 12;
    localparam int AW = 8;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          verify_en = 1'b0;
    logic          coef_valid = 1'b0;
    logic [CW-1:0] coef_data = '0;
    logic          coef_ready, fir_hlt, fir_load, busy, done, err;
    logic [AW-1:0] fir_write_address, fir_read_address;
    logic [CW-1:0] fir_write_value, fir_read_value;

    logic [CW-1:0] mem [256];
    bit            corrupt = 1'b0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            loads = 0;
    logic [CW-1:0] cf [N];
    int            gaps [N];

    fir_coeff_ctrl #(.NTAPS(N), .CW(CW), .AW(AW), .SUMW(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .cfg_start(cfg_start), .verify_en(verify_en),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .fir_hlt(fir_hlt), .fir_load(fir_load), .fir_write_address(fir_write_address),
        .fir_write_value(fir_write_value), .fir_read_address(fir_read_address),
        .fir_read_value(fir_read_value), .busy(busy), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;
    always @(posedge Clk) if (fir_load) mem[fir_write_address] <= fir_write_value;
    assign fir_read_value = mem[fir_read_address] +
                            ((corrupt && fir_read_address == 8'd5) ? 12'd1 : 12'd0);

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; every load pulse must be the next tap in order.
    task automatic step();
        @(posedge Clk);
        #1;
        if (fir_load === 1'b1) begin
            chk("load_addr", int'(fir_write_address), loads);
            chk("load_val", int'(fir_write_value), (loads < N) ? int'(cf[loads]) : -1);
            loads++;
        end
    endtask

    task automatic run_cfg(input string tag, input bit ver, input bit mid_start);
        int start, lat, wsum, rsum, k;
        bit exp_err, seen, hlt_low;
        loads = 0;
        lat = 2 * N + 3 + (ver ? N : 0);
        wsum = 0;
        rsum = 0;
        for (int i = 0; i < N; i++) begin
            lat += gaps[i];
            wsum = (wsum + int'(cf[i])) % 65536;
            rsum = (rsum + ((int'(cf[i]) + ((corrupt && i == 5) ? 1 : 0)) % 4096)) % 65536;
        end
        exp_err = ver && (rsum != wsum);

        cfg_start = 1'b1;
        verify_en = ver;
        start = cyc;
        step();
        cfg_start = 1'b0;
        verify_en = ~ver;
        chk({tag, "_busy_start"}, int'(busy), 1);
        chk({tag, "_hlt_start"}, int'(fir_hlt), 1);
        chk({tag, "_ready_start"}, int'(coef_ready), 1);
        chk({tag, "_err_clear"}, int'(err), 0);

        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                coef_valid = 1'b0;
                step();
            end
            coef_valid = 1'b1;
            coef_data = cf[i];
            if (mid_start && i == 8) cfg_start = 1'b1;
            step();
            cfg_start = 1'b0;
        end
        coef_valid = 1'b0;

        seen = 1'b0;
        hlt_low = 1'b0;
        k = 0;
        while (!seen && k < 400) begin
            step();
            k++;
            if (done === 1'b1) seen = 1'b1;
            else if (fir_hlt !== 1'b1) hlt_low = 1'b1;
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_latency"}, cyc - start, lat);
        chk({tag, "_hlt_run"}, int'(fir_hlt), 0);
        chk({tag, "_busy_run"}, int'(busy), 0);
        chk({tag, "_err"}, int'(err), int'(exp_err));
        chk({tag, "_loads"}, loads, N);
        chk({tag, "_hlt_held"}, int'(hlt_low), 0);
        step();
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_hlt_stay"}, int'(fir_hlt), 0);
    endtask

    initial begin
        bit any_bad;

        // Reset state
        step();
        chk("rst_hlt", int'(fir_hlt), 1);
        chk("rst_load", int'(fir_load), 0);
        chk("rst_ready", int'(coef_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_waddr", int'(fir_write_address), 0);
        chk("rst_raddr", int'(fir_read_address), 0);
        Rst_n = 1'b1;

        // Idle without cfg_start: no loads, stays halted
        any_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (fir_load !== 1'b0 || fir_hlt !== 1'b1 || busy !== 1'b0) any_bad = 1'b1;
        end
        chk("idle_quiet", int'(any_bad), 0);

        // Back-to-back 1..16, no verify
        for (int i = 0; i < N; i++) begin
            cf[i] = CW'(i + 1);
            gaps[i] = 0;
        end
        run_cfg("b2b", 1'b0, 1'b0);

        // Valid toggled every other cycle
        for (int i = 0; i < N; i++) gaps[i] = (i == 0) ? 0 : 1;
        run_cfg("gaps", 1'b0, 1'b0);

        // Verify with clean and corrupted readback
        for (int i = 0; i < N; i++) gaps[i] = 0;
        run_cfg("verify_ok", 1'b1, 1'b0);
        corrupt = 1'b1;
        run_cfg("verify_bad", 1'b1, 1'b0);
        corrupt = 1'b0;

        // Reload all-ones from RUN; a second cfg_start mid-WRITE is ignored
        for (int i = 0; i < N; i++) cf[i] = 12'hFFF;
        run_cfg("reload_fff", 1'b1, 1'b1);

        // Reset during WRITE after 7 taps
        for (int i = 0; i < N; i++) cf[i] = CW'($urandom);
        loads = 0;
        cfg_start = 1'b1;
        verify_en = 1'b0;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            coef_valid = 1'b1;
            coef_data = cf[i];
            step();
        end
        coef_valid = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        chk("abort_ready", int'(coef_ready), 0);
        chk("abort_hlt", int'(fir_hlt), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_load", int'(fir_load), 0);
        step();
        Rst_n = 1'b1;
        step();
        chk("abort_idle_hlt", int'(fir_hlt), 1);
        run_cfg("restart", 1'b1, 1'b0);

        // Randomized configurations
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                cf[i] = CW'($urandom);
                gaps[i] = int'($urandom_range(0, 2));
            end
            corrupt = 1'($urandom_range(0, 1));
            run_cfg("random", 1'($urandom_range(0, 1)), 1'b0);
        end
        corrupt = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
